// File: rtl/mac_dot_sequencer_if.sv
// mac_dot_sequencer_if
//   Bundles the three buses of the dot-product sequencer:
//     s_*   operand beat stream in (valid/ready, a, b, split mode, last flag)
//     mac_* drive to the external combinational MAC and its result back
//     m_*   per-vector result stream out (valid/ready, result, split, count, wrap)
//   Modports:
//     slave  - the sequencer side
//     master - the environment side (operand source, MAC, result sink)
interface mac_dot_sequencer_if #(
  parameter int ACC_W = 48,
  parameter int OP_W  = 8,
  parameter int CNT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [OP_W-1:0]  s_a;
  logic [OP_W-1:0]  s_b;
  logic             s_split;
  logic             s_last;

  logic             mac_split;
  logic [ACC_W-1:0] mac_in;
  logic [OP_W-1:0]  mac_a;
  logic [OP_W-1:0]  mac_b;
  logic [ACC_W-1:0] mac_out;

  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_result;
  logic             m_split;
  logic [CNT_W-1:0] m_count;
  logic             m_wrap;

  modport slave (
    input  s_valid, s_a, s_b, s_split, s_last, mac_out, m_ready,
    output s_ready, mac_split, mac_in, mac_a, mac_b,
           m_valid, m_result, m_split, m_count, m_wrap
  );

  modport master (
    output s_valid, s_a, s_b, s_split, s_last, mac_out, m_ready,
    input  s_ready, mac_split, mac_in, mac_a, mac_b,
           m_valid, m_result, m_split, m_count, m_wrap
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Streaming dot-product controller around an external combinational MAC.
//   Operand beats arrive on bus.s_*; each accepted beat folds a*b into the
//   accumulator through the MAC (bus.mac_*). The beat flagged s_last closes
//   the vector and its result is presented on bus.m_* until taken.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - mac_dot_sequencer_if.slave (operand, MAC and result buses)
module mac_dot_sequencer #(
  parameter int ACC_W = 48,
  parameter int OP_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_dot_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic             rdy_en;
  logic [ACC_W-1:0] acc;
  logic             split_q;
  logic [CNT_W-1:0] cnt;
  logic             wrap_q;

  logic [ACC_W-1:0] m_result_q;
  logic             m_split_q;
  logic [CNT_W-1:0] m_count_q;
  logic             m_wrap_q;

  logic             first;
  logic             accept;
  logic             split_eff;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap_nxt;

  // rdy_en keeps s_ready low through reset and until the first clock edge
  // after release, so no beat can be taken while the block is coming up.
  assign first     = (state_q == IDLE);
  assign bus.s_ready = rdy_en && (state_q != DONE);
  assign accept    = bus.s_valid && bus.s_ready;

  // The mode is latched on the first beat; later s_split changes are ignored.
  assign split_eff = first ? bus.s_split : split_q;

  assign cnt_nxt   = first ? {{(CNT_W-1){1'b0}}, 1'b1} : cnt + 1'b1;
  assign wrap_nxt  = first ? 1'b0 : (wrap_q | (&cnt));

  // MAC drive: a fresh vector starts from zero instead of the stale accumulator.
  assign bus.mac_a     = bus.s_a;
  assign bus.mac_b     = bus.s_b;
  assign bus.mac_in    = first ? '0 : acc;
  assign bus.mac_split = split_eff;

  assign bus.m_valid  = (state_q == DONE);
  assign bus.m_result = m_result_q;
  assign bus.m_split  = m_split_q;
  assign bus.m_count  = m_count_q;
  assign bus.m_wrap   = m_wrap_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = bus.s_last ? DONE : ACC;
      ACC:  if (accept && bus.s_last) state_d = DONE;
      DONE: if (bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_en     <= 1'b0;
      acc        <= '0;
      split_q    <= 1'b0;
      cnt        <= '0;
      wrap_q     <= 1'b0;
      m_result_q <= '0;
      m_split_q  <= 1'b0;
      m_count_q  <= '0;
      m_wrap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_en  <= 1'b1;
      // accumulate stage: MAC result folds back into the accumulator
      if (accept) begin
        acc    <= bus.mac_out;
        cnt    <= cnt_nxt;
        wrap_q <= wrap_nxt;
        if (first) split_q <= bus.s_split;
      end
      // result stage: captured once per vector, held while DONE waits
      if (accept && bus.s_last) begin
        m_result_q <= bus.mac_out;
        m_count_q  <= cnt_nxt;
        m_split_q  <= split_eff;
        m_wrap_q   <= wrap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mac_dot_sequencer_if #(.ACC_W(48), .OP_W(8), .CNT_W(16)) bi ();
  mac_dot_sequencer_if #(.ACC_W(48), .OP_W(8), .CNT_W(2))  bw ();

  mac_dot_sequencer #(.ACC_W(48), .OP_W(8), .CNT_W(16)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bi)
  );

  mac_dot_sequencer #(.ACC_W(48), .OP_W(8), .CNT_W(2)) u_dut_w (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bw)
  );

  // Reference MAC: in + sign-extended signed a*b, wrapped to 48 bits.
  function automatic logic [47:0] mac_model(input logic [47:0] in,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return in + {{32{p[15]}}, p};
  endfunction

  assign bi.mac_out = mac_model(bi.mac_in, bi.mac_a, bi.mac_b);
  assign bw.mac_out = mac_model(bw.mac_in, bw.mac_a, bw.mac_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One accepted beat on the 16-bit-counter DUT; checks the MAC drive first.
  task automatic beat(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic sp, input logic ls,
                      input logic [47:0] exp_in, input logic exp_msp);
    bi.s_valid = 1'b1;
    bi.s_a     = a;
    bi.s_b     = b;
    bi.s_split = sp;
    bi.s_last  = ls;
    #1;
    chk({nm, "_s_ready"}, {63'b0, bi.s_ready}, 64'd1);
    chk({nm, "_mac_in"}, {16'b0, bi.mac_in}, {16'b0, exp_in});
    chk({nm, "_mac_split"}, {63'b0, bi.mac_split}, {63'b0, exp_msp});
    @(posedge clk);
    #1;
    bi.s_valid = 1'b0;
    bi.s_last  = 1'b0;
  endtask

  task automatic chk_result(input string nm, input logic [47:0] res,
                            input logic [15:0] cnt, input logic sp, input logic wr);
    chk({nm, "_m_valid"}, {63'b0, bi.m_valid}, 64'd1);
    chk({nm, "_s_ready_done"}, {63'b0, bi.s_ready}, 64'd0);
    chk({nm, "_m_result"}, {16'b0, bi.m_result}, {16'b0, res});
    chk({nm, "_m_count"}, {48'b0, bi.m_count}, {48'b0, cnt});
    chk({nm, "_m_split"}, {63'b0, bi.m_split}, {63'b0, sp});
    chk({nm, "_m_wrap"}, {63'b0, bi.m_wrap}, {63'b0, wr});
  endtask

  task automatic take(input string nm);
    bi.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bi.m_ready = 1'b0;
    chk({nm, "_m_valid_clr"}, {63'b0, bi.m_valid}, 64'd0);
    chk({nm, "_s_ready_idle"}, {63'b0, bi.s_ready}, 64'd1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        split;
    logic        last;
    logic [47:0] exp_in;
    logic        exp_msp;
    logic [47:0] exp_res;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[5];

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // single beat, split=1
    tbl[0] = '{8'h01, 8'h01, 1'b1, 1'b1, 48'h0, 1'b1, 48'h1, 16'd1};
    // 4-beat vector: 6 - 5 + 1 - 8 = -6; s_split toggled on beat 3 is ignored
    tbl[1] = '{8'h02, 8'h03, 1'b0, 1'b0, 48'h0, 1'b0, 48'h0, 16'd0};
    tbl[2] = '{8'hFF, 8'h05, 1'b0, 1'b0, 48'h6, 1'b0, 48'h0, 16'd0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 48'h1, 1'b0, 48'h0, 16'd0};
    tbl[4] = '{8'h04, 8'hFE, 1'b0, 1'b1, 48'h2, 1'b0, 48'hFFFF_FFFF_FFFA, 16'd4};

    bi.s_valid = 1'b0; bi.s_a = '0; bi.s_b = '0; bi.s_split = 1'b0; bi.s_last = 1'b0;
    bi.m_ready = 1'b0;
    bw.s_valid = 1'b0; bw.s_a = '0; bw.s_b = '0; bw.s_split = 1'b0; bw.s_last = 1'b0;
    bw.m_ready = 1'b0;

    // reset state
    rst_n = 1'b0;
    #12;
    chk("rst_s_ready", {63'b0, bi.s_ready}, 64'd0);
    chk("rst_m_valid", {63'b0, bi.m_valid}, 64'd0);
    chk("rst_m_result", {16'b0, bi.m_result}, 64'd0);
    chk("rst_m_count", {48'b0, bi.m_count}, 64'd0);
    chk("rst_m_split", {63'b0, bi.m_split}, 64'd0);
    chk("rst_m_wrap", {63'b0, bi.m_wrap}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready_pre_edge", {63'b0, bi.s_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("rel_s_ready_post_edge", {63'b0, bi.s_ready}, 64'd1);

    // m_ready while idle must do nothing
    bi.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bi.m_ready = 1'b0;
    chk("idle_mready_m_valid", {63'b0, bi.m_valid}, 64'd0);

    // table-driven vectors
    for (int i = 0; i < 5; i++) begin
      beat($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].split, tbl[i].last,
           tbl[i].exp_in, tbl[i].exp_msp);
      if (tbl[i].last) begin
        chk_result($sformatf("tbl%0d", i), tbl[i].exp_res, tbl[i].exp_cnt, tbl[i].exp_msp, 1'b0);
        take($sformatf("tbl%0d", i));
      end
    end

    // backpressure: (5,5),(1,-1) -> 24, held 5 cycles
    beat("bp_b1", 8'h05, 8'h05, 1'b1, 1'b0, 48'h0, 1'b1);
    beat("bp_b2", 8'h01, 8'hFF, 1'b0, 1'b1, 48'd25, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk_result($sformatf("bp_hold%0d", c), 48'd24, 16'd2, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    take("bp");

    // bubbles and mid-vector mode change: 12 - 4 + 7 = 15
    beat("bub_b1", 8'h03, 8'h04, 1'b0, 1'b0, 48'h0, 1'b0);
    bi.s_split = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bub_gap%0d_mac_split", c), {63'b0, bi.mac_split}, 64'd0);
      chk($sformatf("bub_gap%0d_m_valid", c), {63'b0, bi.m_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    beat("bub_b2", 8'hFE, 8'h02, 1'b1, 1'b0, 48'd12, 1'b0);
    beat("bub_b3", 8'h07, 8'h01, 1'b1, 1'b1, 48'd8, 1'b0);
    chk_result("bub", 48'd15, 16'd3, 1'b0, 1'b0);
    take("bub");

    // reset mid-vector
    beat("rmv_b1", 8'h01, 8'h01, 1'b0, 1'b0, 48'h0, 1'b0);
    beat("rmv_b2", 8'h01, 8'h01, 1'b0, 1'b0, 48'h1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmv_s_ready", {63'b0, bi.s_ready}, 64'd0);
    chk("rmv_m_valid", {63'b0, bi.m_valid}, 64'd0);
    chk("rmv_m_result", {16'b0, bi.m_result}, 64'd0);
    chk("rmv_m_count", {48'b0, bi.m_count}, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rmv_rel_s_ready_pre", {63'b0, bi.s_ready}, 64'd0);
    @(posedge clk);
    #1;
    beat("rmv_new", 8'h03, 8'h03, 1'b0, 1'b1, 48'h0, 1'b0);
    chk_result("rmv_new", 48'd9, 16'd1, 1'b0, 1'b0);
    take("rmv_new");

    // counter wrap on the CNT_W=2 instance: 5 beats then 3 beats of (1,1)
    for (int v = 0; v < 2; v++) begin
      int nb;
      nb = (v == 0) ? 5 : 3;
      for (int k = 0; k < nb; k++) begin
        bw.s_valid = 1'b1;
        bw.s_a     = 8'h01;
        bw.s_b     = 8'h01;
        bw.s_split = 1'b0;
        bw.s_last  = (k == nb - 1);
        #1;
        chk($sformatf("wrap%0d_b%0d_mac_in", v, k), {16'b0, bw.mac_in}, 64'(k));
        @(posedge clk);
        #1;
      end
      bw.s_valid = 1'b0;
      bw.s_last  = 1'b0;
      chk($sformatf("wrap%0d_m_valid", v), {63'b0, bw.m_valid}, 64'd1);
      chk($sformatf("wrap%0d_m_result", v), {16'b0, bw.m_result}, 64'(nb));
      chk($sformatf("wrap%0d_m_count", v), {62'b0, bw.m_count}, (v == 0) ? 64'd1 : 64'd3);
      chk($sformatf("wrap%0d_m_wrap", v), {63'b0, bw.m_wrap}, (v == 0) ? 64'd1 : 64'd0);
      bw.m_ready = 1'b1;
      @(posedge clk);
      #1;
      bw.m_ready = 1'b0;
      chk($sformatf("wrap%0d_m_valid_clr", v), {63'b0, bw.m_valid}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
